// File: rtl/bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI bridge: default IDs, FSM encodings
// and the SRAM size to AXI size conversion.
package bridge_pkg;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ADDR = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_SEND = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  function automatic logic [2:0] size_to_axsize(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/sram_axi_wr_ctrl.sv
// Single-beat AXI write engine for the data port: accepts one write, drives AW and W
// independently, then waits for the B response.
module sram_axi_wr_ctrl
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic        i_block,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_wdata,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [1:0]  o_state,
  output logic [31:0] o_awaddr,
  output logic [2:0]  o_awsize,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic        i_bvalid,
  output logic        o_bready
);

  wr_state_t   r_state;
  wr_state_t   w_next;
  logic        r_aw_pend;
  logic        r_w_pend;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        w_accept;
  logic        w_aw_done;
  logic        w_w_done;

  assign w_accept  = (r_state == WR_IDLE) & i_req & ~i_block;
  // A channel counts as done once its handshake happened, now or in an earlier cycle.
  assign w_aw_done = ~r_aw_pend | i_awready;
  assign w_w_done  = ~r_w_pend | i_wready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      WR_IDLE: if (w_accept) w_next = WR_SEND;
      WR_SEND: if (w_aw_done & w_w_done) w_next = WR_RESP;
      WR_RESP: if (i_bvalid) w_next = WR_IDLE;
      default: w_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= WR_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
      r_awaddr  <= '0;
      r_awsize  <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_aw_pend <= 1'b1;
      r_w_pend  <= 1'b1;
      r_awaddr  <= i_addr;
      r_awsize  <= size_to_axsize(i_size);
      r_wstrb   <= i_wstrb;
      r_wdata   <= i_wdata;
    end else begin
      if (i_awready) r_aw_pend <= 1'b0;
      if (i_wready)  r_w_pend  <= 1'b0;
    end
  end

  assign o_addr_ok = w_accept;
  assign o_bready  = (r_state == WR_RESP);
  assign o_data_ok = o_bready & i_bvalid;
  assign o_state   = r_state;
  assign o_awaddr  = r_awaddr;
  assign o_awsize  = r_awsize;
  assign o_awvalid = r_aw_pend;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_wvalid  = r_w_pend;

endmodule

// File: rtl/sram_axi_bridge.sv
// Shares one AXI master between the inst and data SRAM-like ports. Reads are arbitrated
// here (data first); writes are handled by sram_axi_wr_ctrl.
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic        o_dbg_rd_state,
  output logic [1:0]  o_dbg_wr_state
);

  rd_state_t   r_rd_state;
  rd_state_t   w_rd_next;
  logic        r_inst_rd_busy;
  logic        r_data_rd_busy;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [3:0]  r_arid;
  logic        w_data_grant;
  logic        w_inst_grant;
  logic        w_ar_done;
  logic        w_inst_r;
  logic        w_data_r;
  logic        w_wr_idle;
  logic        w_wr_block;
  logic        w_wr_addr_ok;
  logic        w_wr_data_ok;
  logic [1:0]  w_wr_state;

  assign w_wr_idle  = (w_wr_state == WR_IDLE);
  assign w_ar_done  = (r_rd_state == RD_ADDR) & arready;
  assign w_inst_r   = rvalid & (rid == INST_ID);
  assign w_data_r   = rvalid & (rid == DATA_ID);
  // A data write must not start while a data read is queued on AR or still in flight.
  assign w_wr_block = r_data_rd_busy | ((r_rd_state == RD_ADDR) & (r_arid == DATA_ID));

  always_comb begin
    w_rd_next    = r_rd_state;
    w_data_grant = 1'b0;
    w_inst_grant = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (data_sram_req & ~data_sram_wr & ~r_data_rd_busy & w_wr_idle) begin
          w_data_grant = 1'b1;
          w_rd_next    = RD_ADDR;
        end else if (inst_sram_req & ~r_inst_rd_busy) begin
          w_inst_grant = 1'b1;
          w_rd_next    = RD_ADDR;
        end
      end
      RD_ADDR: if (arready) w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_rd_state <= RD_IDLE;
    else         r_rd_state <= w_rd_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_araddr       <= '0;
      r_arsize       <= '0;
      r_arid         <= '0;
      r_inst_rd_busy <= 1'b0;
      r_data_rd_busy <= 1'b0;
    end else begin
      if (w_data_grant) begin
        r_araddr <= data_sram_addr;
        r_arsize <= size_to_axsize(data_sram_size);
        r_arid   <= DATA_ID;
      end else if (w_inst_grant) begin
        r_araddr <= inst_sram_addr;
        r_arsize <= size_to_axsize(inst_sram_size);
        r_arid   <= INST_ID;
      end
      r_inst_rd_busy <= (r_inst_rd_busy & ~w_inst_r) | (w_ar_done & (r_arid == INST_ID));
      r_data_rd_busy <= (r_data_rd_busy & ~w_data_r) | (w_ar_done & (r_arid == DATA_ID));
    end
  end

  sram_axi_wr_ctrl u_wr_ctrl (
    .clk       (clk),
    .resetn    (resetn),
    .i_req     (data_sram_req & data_sram_wr),
    .i_block   (w_wr_block),
    .i_addr    (data_sram_addr),
    .i_size    (data_sram_size),
    .i_wstrb   (data_sram_wstrb),
    .i_wdata   (data_sram_wdata),
    .o_addr_ok (w_wr_addr_ok),
    .o_data_ok (w_wr_data_ok),
    .o_state   (w_wr_state),
    .o_awaddr  (awaddr),
    .o_awsize  (awsize),
    .o_awvalid (awvalid),
    .i_awready (awready),
    .o_wdata   (wdata),
    .o_wstrb   (wstrb),
    .o_wvalid  (wvalid),
    .i_wready  (wready),
    .i_bvalid  (bvalid),
    .o_bready  (bready)
  );

  // Responses are qualified by the busy bits so a stray beat after reset is ignored.
  assign inst_sram_addr_ok = w_inst_grant;
  assign inst_sram_data_ok = w_inst_r & r_inst_rd_busy;
  assign inst_sram_rdata   = rdata;
  assign data_sram_addr_ok = w_data_grant | w_wr_addr_ok;
  assign data_sram_data_ok = (w_data_r & r_data_rd_busy) | w_wr_data_ok;
  assign data_sram_rdata   = rdata;

  assign arid           = r_arid;
  assign araddr         = r_araddr;
  assign arsize         = r_arsize;
  assign arvalid        = (r_rd_state == RD_ADDR);
  assign rready         = 1'b1;
  assign o_dbg_rd_state = r_rd_state;
  assign o_dbg_wr_state = w_wr_state;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays core and AXI slave, with per-port
// expected read-data queues filled on request acceptance and drained on data_ok.
module tb_sram_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;
  logic        o_dbg_rd_state;
  logic [1:0]  o_dbg_wr_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .o_dbg_rd_state(o_dbg_rd_state), .o_dbg_wr_state(o_dbg_wr_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
    if (addr == 32'h1C00_0000) return 32'h0280_0000;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver: AXI slave accepts the pending AR after checking its fields
  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] sz);
    int n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    check1("ar_valid_wait", arvalid, 1'b1);
    check("arid", 32'(arid), 32'(id));
    check("araddr", araddr, addr);
    check("arsize", 32'(arsize), 32'(sz));
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  // driver: one R beat, scoreboard pops the port selected by id
  task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1'b1;
    rid    = id;
    rdata  = d;
    #1;
    if (id == 4'd0) begin
      check1("inst_data_ok", inst_sram_data_ok, 1'b1);
      check1("data_ok_quiet", data_sram_data_ok, 1'b0);
      if (exp_inst_q.size() == 0) check1("inst_q_underflow", 1'b1, 1'b0);
      else check("inst_rdata", inst_sram_rdata, exp_inst_q.pop_front());
    end else begin
      check1("data_data_ok", data_sram_data_ok, 1'b1);
      check1("inst_ok_quiet", inst_sram_data_ok, 1'b0);
      if (exp_data_q.size() == 0) check1("data_q_underflow", 1'b1, 1'b0);
      else check("data_rdata", data_sram_rdata, exp_data_q.pop_front());
    end
    tick();
    rvalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    repeat (3) tick();
    resetn = 1'b1;
    #1;
    check1("rst_arvalid", arvalid, 1'b0);
    check1("rst_awvalid", awvalid, 1'b0);
    check1("rst_wvalid", wvalid, 1'b0);
    check1("rst_rready", rready, 1'b1);
    check1("rst_bready", bready, 1'b0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_rd_state", 32'(o_dbg_rd_state), 32'h0);
    check("rst_wr_state", 32'(o_dbg_wr_state), 32'h0);
    check1("rst_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    check1("rst_data_data_ok", data_sram_data_ok, 1'b0);
    tick();

    // inst read, zero-wait slave: addr_ok cycle 0, arvalid cycle 1, data_ok cycle 2
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
    #1;
    check1("t1_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    check1("t1_arvalid_late", arvalid, 1'b0);
    exp_inst_q.push_back(exp_rdata(32'h1C00_0000));
    tick();
    inst_sram_req = 0;
    ar_hs(4'd0, 32'h1C00_0000, 3'd2);
    r_beat(4'd0, exp_rdata(32'h1C00_0000));

    // simultaneous inst and data reads: data first, inst after; responses out of order
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_1234; data_sram_size = 2'd1;
    #1;
    check1("t2_data_addr_ok", data_sram_addr_ok, 1'b1);
    check1("t2_inst_blocked", inst_sram_addr_ok, 1'b0);
    exp_data_q.push_back(exp_rdata(32'h0000_1234));
    tick();
    data_sram_req = 0;
    #1;
    check1("t2_inst_wait", inst_sram_addr_ok, 1'b0);
    ar_hs(4'd1, 32'h0000_1234, 3'd1);
    check1("t2_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    exp_inst_q.push_back(exp_rdata(32'h1C00_0040));
    tick();
    inst_sram_req = 0;
    ar_hs(4'd0, 32'h1C00_0040, 3'd2);
    r_beat(4'd1, exp_rdata(32'h0000_1234));
    r_beat(4'd0, exp_rdata(32'h1C00_0040));

    // data write, awready two cycles ahead of wready
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h80; data_sram_size = 2'd1;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hDEAD_BEEF;
    #1;
    check1("t3_addr_ok", data_sram_addr_ok, 1'b1);
    tick();
    data_sram_req = 0; data_sram_wr = 0;
    check1("t3_awvalid", awvalid, 1'b1);
    check1("t3_wvalid", wvalid, 1'b1);
    check("t3_awaddr", awaddr, 32'h80);
    check("t3_awsize", 32'(awsize), 32'd1);
    check("t3_wdata", wdata, 32'hDEAD_BEEF);
    check("t3_wstrb", 32'(wstrb), 32'h3);
    awready = 1;
    tick();
    awready = 0;
    check1("t3_aw_dropped", awvalid, 1'b0);
    check1("t3_w_held", wvalid, 1'b1);
    check1("t3_no_bready", bready, 1'b0);
    tick();
    check1("t3_w_held2", wvalid, 1'b1);
    wready = 1;
    tick();
    wready = 0;
    check1("t3_w_dropped", wvalid, 1'b0);
    check1("t3_bready", bready, 1'b1);

    // data read while the write waits on B: held off until after bvalid
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h100; data_sram_size = 2'd2;
    #1;
    check1("t4_held", data_sram_addr_ok, 1'b0);
    tick();
    check1("t4_held2", data_sram_addr_ok, 1'b0);
    bvalid = 1;
    #1;
    check1("t3_wr_data_ok", data_sram_data_ok, 1'b1);
    check1("t4_held_bvalid", data_sram_addr_ok, 1'b0);
    tick();
    bvalid = 0;
    #1;
    check1("t3_single_data_ok", data_sram_data_ok, 1'b0);
    check1("t4_addr_ok", data_sram_addr_ok, 1'b1);
    exp_data_q.push_back(exp_rdata(32'h100));
    tick();
    data_sram_req = 0;
    ar_hs(4'd1, 32'h100, 3'd2);
    r_beat(4'd1, exp_rdata(32'h100));

    // reset while arvalid is held, with an inst read already in flight
    inst_sram_req = 1; inst_sram_addr = 32'h2000;
    #1;
    check1("t6_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    exp_inst_q.push_back(exp_rdata(32'h2000));
    tick();
    inst_sram_req = 0;
    ar_hs(4'd0, 32'h2000, 3'd2);
    inst_sram_req = 1; inst_sram_addr = 32'h2004;
    #1;
    check1("t6_inst_busy", inst_sram_addr_ok, 1'b0);
    inst_sram_req = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h3000;
    #1;
    check1("t6_data_addr_ok", data_sram_addr_ok, 1'b1);
    tick();
    data_sram_req = 0;
    check1("t6_arvalid", arvalid, 1'b1);
    resetn = 0;
    tick();
    exp_inst_q.delete();
    exp_data_q.delete();
    check1("t6_arvalid_rst", arvalid, 1'b0);
    check("t6_rd_state_rst", 32'(o_dbg_rd_state), 32'h0);
    rvalid = 1; rid = 4'd0; rdata = 32'h1111_1111;
    #1;
    check1("t6_no_inst_ok", inst_sram_data_ok, 1'b0);
    rid = 4'd1;
    #1;
    check1("t6_no_data_ok", data_sram_data_ok, 1'b0);
    rvalid = 0;
    tick();
    resetn = 1;
    tick();
    inst_sram_req = 1; inst_sram_addr = 32'h4000;
    #1;
    check1("t6_inst_free", inst_sram_addr_ok, 1'b1);
    exp_inst_q.push_back(exp_rdata(32'h4000));
    tick();
    inst_sram_req = 0;
    ar_hs(4'd0, 32'h4000, 3'd2);
    r_beat(4'd0, exp_rdata(32'h4000));

    // report
    check("end_inst_q_empty", 32'(exp_inst_q.size()), 32'd0);
    check("end_data_q_empty", 32'(exp_data_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Arbiter/bridge that shares one AXI master port between the core's inst and data SRAM-like interfaces (req / addr_ok / data_ok). Sits between `cpu_core` and the SoC AXI interconnect, inside the CPU top. Converts each accepted SRAM-like request into a single-beat AXI transaction. Orders data-side requests so a data read never overtakes a pending data write.

## Interface
- `INST_ID`, 4'd0: ARID used for instruction fetches.
- `DATA_ID`, 4'd1: ARID/AWID used for data accesses.
- `clk  in  1`: core clock.
- `resetn  in  1`: synchronous, active-low reset.
- `{inst,data}_sram_req  in  1`: request valid.
- `{inst,data}_sram_wr  in  1`: 1 = write. Inst-side writes are never issued.
- `{inst,data}_sram_size  in  2`: 0 = byte, 1 = half, 2 = word.
- `{inst,data}_sram_wstrb  in  4`: byte strobes, writes only.
- `{inst,data}_sram_addr  in  32`: physical address.
- `{inst,data}_sram_wdata  in  32`: write data.
- `{inst,data}_sram_addr_ok  out  1`: request accepted this cycle.
- `{inst,data}_sram_data_ok  out  1`: response this cycle.
- `{inst,data}_sram_rdata  out  32`: read data, valid with data_ok.
- `arid out 4`, `araddr out 32`, `arsize out 3`, `arvalid out 1`, `arready in 1`: AR channel.
- `rid in 4`, `rdata in 32`, `rvalid in 1`, `rready out 1`: R channel. rresp is ignored.
- `awaddr out 32`, `awsize out 3`, `awvalid out 1`, `awready in 1`: AW channel. AWID = DATA_ID.
- `wdata out 32`, `wstrb out 4`, `wvalid out 1`, `wready in 1`: W channel.
- `bvalid in 1`, `bready out 1`: B channel.
- Constant AXI fields (len = 0, burst = INCR, lock, cache, prot, wlast = 1) are tied at the top and are not ports of this block.

## Operation
- Read-issue FSM RD_IDLE → RD_ADDR → RD_IDLE.
  - In RD_IDLE, grant data if `data_sram_req & ~data_sram_wr & ~data_rd_busy & wr_state == WR_IDLE`.
  - Otherwise grant inst if `inst_sram_req & ~inst_rd_busy`.
  - Data has fixed priority over inst.
- Read grant actions:
  - Assert the matching addr_ok combinationally in the grant cycle.
  - Latch addr, {1'b0, size} and id, then go to RD_ADDR.
- RD_ADDR behaviour:
  - `arvalid = 1` with the latched fields held stable until `arready`.
  - On arready, set that id's `*_rd_busy` and return to RD_IDLE.
- `rready` is constantly 1.
- R-channel response: on `rvalid`, rid == INST_ID pulses inst_data_ok and rid == DATA_ID pulses data_data_ok. rdata passes through, and the matching busy bit clears.
- Write FSM WR_IDLE → WR_SEND → WR_RESP → WR_IDLE.
  - In WR_IDLE, accept if `data_sram_req & data_sram_wr & ~data_rd_busy & ~(rd_state == RD_ADDR & latched id == DATA_ID)`.
  - On accept, pulse data_addr_ok and latch addr, size, wstrb and wdata.
- WR_SEND: awvalid and wvalid both start at 1. Each drops independently on its own handshake. Move to WR_RESP once both have completed, in either order or the same cycle.
- WR_RESP: `bready = 1`. On bvalid, pulse data_data_ok and return to WR_IDLE.
- Read and write acceptance on the data port are mutually exclusive by construction. At most one data transaction is outstanding, so data responses are in order.
- One inst read may be outstanding concurrently with one data read or write.

## Timing
- Reset values: all AXI valids 0, `rready` 1, `bready` 0, both busy bits 0, FSMs idle, latched fields 0, addr_ok/data_ok 0.
- addr_ok is combinational in the request cycle.
- arvalid/awvalid rise the cycle after acceptance.
- data_ok is combinational in the rvalid/bvalid cycle.
- Minimum read latency is 2 cycles (req → data_ok) with a zero-wait slave.
- Inst is starved only while data requests win every RD_IDLE cycle. This is accepted behaviour.
- A new read grant is possible in the cycle after arready.
- Reset mid-transaction returns everything to reset values next cycle and generates no data_ok. The interconnect shares `resetn`.

## Structure
- Shared package `bridge_pkg` holds:
  - INST_ID and DATA_ID defaults.
  - RD_IDLE/RD_ADDR and WR_IDLE/WR_SEND/WR_RESP state encodings.
  - A `size_to_axsize` constant function.
- One sub-module `sram_axi_wr_ctrl` contains the write FSM and the AW/W/B channels. The read arbitration and R-channel demux stay in the top.

## Test plan
- Inst read of addr 0x1C000000, arready and rvalid one cycle later with rdata 0x02800000 → inst_addr_ok in cycle 0, arvalid in cycle 1 with arid 0 and arsize 2, inst_data_ok and rdata 0x02800000 in cycle 2.
- Simultaneous inst and data read requests → data_addr_ok first (arid 1), inst_addr_ok on the next RD_IDLE cycle.
- Data write to 0x80 with wstrb 4'b0011 and awready 2 cycles before wready → aw and w handshakes on separate cycles, one data_data_ok on bvalid.
- Data read issued while a write is in WR_RESP → no data_addr_ok until the cycle after bvalid.
- Responses out of order (rid 1 returns before rid 0) → each data_ok routes to the correct port with its own rdata.
- resetn low while arvalid is held → arvalid 0 next cycle, busy bits clear, no spurious data_ok.
